mem_arbiter: RTL and testbench

//  Shares the single-port unified memory (64-bit lines, 14-bit line address, 4-clock access, re/we/rdy) between I-cache fill and D-cache fill/writeback.

---
 rtl/mem_arb_pkg.sv | 33 +++
 rtl/mem_arb_rr2.sv | 33 +++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ----------------------------------------------------------------------------
// mem_arb_pkg
//  Shared definitions for the unified-memory arbiter: FSM state encoding,
//  requester identifiers and the default line geometry.
//  No ports; imported by mem_arb_rr2 and mem_arbiter.
// ----------------------------------------------------------------------------
package mem_arb_pkg;

  // Line geometry: a line address is the byte address >> 3, so a line is 64 bits.
  localparam int LINE_ADDR_W = 14;
  localparam int LINE_W      = 64;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  // Requester identifiers. The numeric value is also the bit position of
  // that requester in the packed request vector handed to the picker.
  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

  // The requester that did not win last time.
  function automatic req_id_e other_req(input req_id_e id);
    return (id == REQ_I) ? REQ_D : REQ_I;
  endfunction

endpackage : mem_arb_pkg

// File: rtl/mem_arb_rr2.sv
// ----------------------------------------------------------------------------
// mem_arb_rr2
//  Two-input round-robin picker. Purely combinational; the history flop
//  (last winner) is owned by the caller.
//  Ports:
//   req    in  [1:0]     request vector, bit REQ_I = I-cache, bit REQ_D = D-cache
//   last   in  req_id_e  requester granted most recently
//   valid  out           at least one request is present
//   grant  out req_id_e  chosen requester (meaningful only when valid)
// ----------------------------------------------------------------------------
module mem_arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    last,
  output logic       valid,
  output req_id_e    grant
);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    valid = |req;
    grant = REQ_I;
    unique case (req)
      2'b01:   grant = REQ_I;
      2'b10:   grant = REQ_D;
      2'b11:   grant = other_req(last);  // contention: alternate
      default: grant = REQ_I;
    endcase
  end

endmodule : mem_arb_rr2

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//  Shares the single-port unified memory between I-cache fills and D-cache
//  fills/writebacks. One request is latched at a time, the memory strobe is
//  issued for exactly one cycle, address/wdata stay stable until mem_rdy, and
//  the owner gets a one-cycle done pulse with its read data. Contention is
//  resolved round-robin. An access that never sees mem_rdy is abandoned after
//  TIMEOUT wait cycles, returns zero data and sets the sticky err flag.
//
//  Ports:
//   clk, rst             clock, asynchronous active-high reset
//   i_req/i_addr         I-cache read request (held until i_done)
//   i_done/i_rdata       I-cache completion pulse and line data
//   d_req/d_we/d_addr    D-cache request (d_we=1 writeback, 0 fill)
//   d_wdata              D-cache writeback line
//   d_done/d_rdata       D-cache completion pulse and line data
//   mem_re/mem_we        single-cycle memory strobes (issue cycle only)
//   mem_addr/mem_wdata   memory address and write data, held through wait
//   mem_rdata/mem_rdy    memory read data and completion flag
//   busy                 sequencer is not idle
//   err                  sticky timeout flag, cleared only by rst
//
//  Timing (ISSUE = T0): strobe at T0, mem_rdy at T4, done at T5, IDLE at T6,
//  so the next strobe is T7 at the earliest and memory always sees an idle
//  cycle between accesses.
// ----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int DATA_W  = LINE_W,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [DATA_W-1:0] i_rdata,
  // D-cache side
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  // Unified memory side
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  // Status
  output logic              busy,
  output logic              err
);

  localparam int                CNT_W    = $clog2(TIMEOUT + 1);
  // Counter value during the last wait cycle allowed before giving up.
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e          state_q, state_d;
  req_id_e             owner_q;
  req_id_e             last_grant_q;
  logic                op_we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [CNT_W-1:0]    wait_cnt_q;
  logic                err_q;
  logic [DATA_W-1:0]   i_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;

  logic                pick_valid;
  req_id_e             pick_id;
  logic                timed_out;

  // --------------------------------------------------------------------------
  // Round-robin choice between the two caches (only consumed in IDLE)
  // --------------------------------------------------------------------------
  mem_arb_rr2 u_rr2 (
    .req   ({d_req, i_req}),
    .last  (last_grant_q),
    .valid (pick_valid),
    .grant (pick_id)
  );

  // Memory readiness wins over the timeout if both land on the same cycle.
  assign timed_out = (wait_cnt_q == CNT_LAST) && !mem_rdy;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_valid) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (mem_rdy || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs decoded from the current state
  // --------------------------------------------------------------------------
  always_comb begin
    mem_re = 1'b0;
    mem_we = 1'b0;
    i_done = 1'b0;
    d_done = 1'b0;
    busy   = (state_q != IDLE);
    unique case (state_q)
      ISSUE: begin
        mem_re = !op_we_q;
        mem_we =  op_we_q;
      end
      DONE: begin
        i_done = (owner_q == REQ_I);
        d_done = (owner_q == REQ_D);
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request latch, wait counter, returned data and status
  // --------------------------------------------------------------------------
  // NOTE: the wide data registers are reset as well, because reset must present
  // all-zero read data and memory address/data, not whatever was left behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q      <= REQ_I;
      last_grant_q <= REQ_I;
      op_we_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            owner_q <= pick_id;
            // The I-cache only ever reads.
            if (pick_id == REQ_D) begin
              op_we_q <= d_we;
              addr_q  <= d_addr;
              wdata_q <= d_wdata;
            end else begin
              op_we_q <= 1'b0;
              addr_q  <= i_addr;
              wdata_q <= '0;
            end
          end
        end

        ISSUE: wait_cnt_q <= '0;

        WAIT: begin
          wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          if (mem_rdy) begin
            // Only reads return data; a completed writeback leaves d_rdata alone.
            if (!op_we_q) begin
              if (owner_q == REQ_D) d_rdata_q <= mem_rdata;
              else                  i_rdata_q <= mem_rdata;
            end
          end else if (timed_out) begin
            err_q <= 1'b1;
            if (owner_q == REQ_D) d_rdata_q <= '0;
            else                  i_rdata_q <= '0;
          end
        end

        DONE: last_grant_q <= owner_q;

        default: ;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign err       = err_q;

  // --------------------------------------------------------------------------
  // Protocol invariants
  // --------------------------------------------------------------------------
  a_strobe_excl : assert property (@(posedge clk) disable iff (rst)
    !(mem_re && mem_we));
  a_done_excl   : assert property (@(posedge clk) disable iff (rst)
    !(i_done && d_done));
  a_done_state  : assert property (@(posedge clk) disable iff (rst)
    (i_done || d_done) |-> (state_q == DONE));

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_arbiter
//  Directed bench for mem_arbiter with a behavioural 4-clock unified memory:
//  a strobe at T0 produces mem_rdy (and read data) at T4. Unwritten lines read
//  back as four 16-bit words {4a+3, 4a+2, 4a+1, 4a}. Outputs are sampled on
//  the falling edge; inputs change right after sampling.
// ----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req = 1'b0;
  logic [13:0] i_addr = '0;
  logic        i_done;
  logic [63:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [13:0] d_addr = '0;
  logic [63:0] d_wdata = '0;
  logic        d_done;
  logic [63:0] d_rdata;
  logic        mem_re, mem_we;
  logic [13:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_rdy;
  logic        busy, err;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_done    (i_done),
    .i_rdata   (i_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_done    (d_done),
    .d_rdata   (d_rdata),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rdy   (mem_rdy),
    .busy      (busy),
    .err       (err)
  );

  // --------------------------------------------------------------------------
  // Unified memory model
  // --------------------------------------------------------------------------
  logic [63:0] wr_mem [int];
  logic        stall = 1'b0;   // 1: memory never reports ready
  int          mcnt;
  logic [13:0] maddr;

  function automatic logic [63:0] init_line(input logic [13:0] a);
    logic [15:0] w;
    w = {a, 2'b00};
    return {w + 16'd3, w + 16'd2, w + 16'd1, w};
  endfunction

  function automatic logic [63:0] mem_line(input logic [13:0] a);
    if (wr_mem.exists(int'(a))) return wr_mem[int'(a)];
    return init_line(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mcnt      <= 0;
      maddr     <= '0;
      mem_rdy   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_rdy <= 1'b0;
      if (mem_re || mem_we) begin
        mcnt  <= 1;
        maddr <= mem_addr;
        if (mem_we) wr_mem[int'(mem_addr)] = mem_wdata;
      end else if (mcnt != 0) begin
        if (mcnt == 3) begin
          mcnt <= 0;
          if (!stall) begin
            mem_rdy   <= 1'b1;
            mem_rdata <= mem_line(maddr);
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Continuous protocol monitor
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      vectors++;
      if ((mem_re && mem_we) || (i_done && d_done) || ((i_done || d_done) && !busy)) begin
        miscompares++;
        $display("FAIL monitor t=%0t: re=%b we=%b i_done=%b d_done=%b busy=%b (want no double strobe/done, done only while busy)",
                 $time, mem_re, mem_we, i_done, d_done, busy);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Helpers
  // --------------------------------------------------------------------------
  task automatic apply_reset();
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Raise one request, wait (bounded) for the owner's done, then drop it.
  task automatic run_access(input logic is_d, input logic we, input logic [13:0] a,
                            input logic [63:0] wd, output logic [63:0] rd,
                            output int lat, output logic seen);
    if (is_d) begin d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; end
    else      begin i_req = 1'b1; i_addr = a; end
    seen = 1'b0; lat = 0; rd = '0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (is_d ? d_done : i_done) begin
        seen = 1'b1; lat = k; rd = is_d ? d_rdata : i_rdata;
      end
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({busy, mem_re, mem_we, i_done, d_done, err} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: busy/re/we/i_done/d_done/err=%b want 000000",
               {busy, mem_re, mem_we, i_done, d_done, err});
    end
    vectors++;
    if ({i_rdata, d_rdata, mem_wdata, mem_addr} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: i_rdata=%h d_rdata=%h mem_wdata=%h mem_addr=%h want all 0",
               i_rdata, d_rdata, mem_wdata, mem_addr);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    i_req = 1'b1; i_addr = 14'h0010;
    @(negedge clk);  // T0
    vectors++;
    if ({mem_re, mem_we, busy} !== 3'b101 || mem_addr !== 14'h0010) begin
      miscompares++;
      $display("FAIL i_read_issue: re/we/busy=%b addr=%h want 101 addr 0010",
               {mem_re, mem_we, busy}, mem_addr);
    end
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      vectors++;
      if ({mem_re, mem_we} !== 2'b00 || mem_rdy !== (t == 4) || i_done !== 1'b0) begin
        miscompares++;
        $display("FAIL i_read_wait T%0d: re/we=%b rdy=%b i_done=%b want 00 rdy=%0d done=0",
                 t, {mem_re, mem_we}, mem_rdy, i_done, (t == 4));
      end
    end
    @(negedge clk);  // T5
    vectors++;
    if (i_done !== 1'b1 || d_done !== 1'b0 || i_rdata !== 64'h0043_0042_0041_0040 || d_rdata !== '0) begin
      miscompares++;
      $display("FAIL i_read_done: i_done=%b d_done=%b i_rdata=%h d_rdata=%h want 1 0 0043004200410040 0",
               i_done, d_done, i_rdata, d_rdata);
    end
    i_req = 1'b0;
    @(negedge clk);  // T6
    vectors++;
    if (busy !== 1'b0 || i_done !== 1'b0) begin
      miscompares++;
      $display("FAIL i_read_idle: busy=%b i_done=%b want 0 0", busy, i_done);
    end
  endtask

  task automatic test_d_write_fill();
    logic [63:0] rd;
    int          lat;
    logic        seen;
    d_req = 1'b1; d_we = 1'b1; d_addr = 14'h0020; d_wdata = 64'hDEADBEEF_CAFEF00D;
    @(negedge clk);  // T0
    vectors++;
    if ({mem_re, mem_we} !== 2'b01 || mem_addr !== 14'h0020 || mem_wdata !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL d_write_issue: re/we=%b addr=%h wdata=%h want 01 0020 deadbeefcafef00d",
               {mem_re, mem_we}, mem_addr, mem_wdata);
    end
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      vectors++;
      if ({mem_re, mem_we} !== 2'b00 || mem_wdata !== 64'hDEADBEEF_CAFEF00D || mem_addr !== 14'h0020) begin
        miscompares++;
        $display("FAIL d_write_hold T%0d: re/we=%b addr=%h wdata=%h want 00 0020 deadbeefcafef00d",
                 t, {mem_re, mem_we}, mem_addr, mem_wdata);
      end
    end
    @(negedge clk);  // T5
    vectors++;
    if (d_done !== 1'b1 || i_done !== 1'b0) begin
      miscompares++;
      $display("FAIL d_write_done: d_done=%b i_done=%b want 1 0", d_done, i_done);
    end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);

    run_access(1'b1, 1'b0, 14'h0020, '0, rd, lat, seen);
    vectors++;
    if (!seen || lat != 6 || rd !== 64'hDEADBEEF_CAFEF00D) begin
      miscompares++;
      $display("FAIL d_fill: seen=%b latency=%0d rdata=%h want 1 6 deadbeefcafef00d", seen, lat, rd);
    end
    vectors++;
    if (i_rdata !== 64'h0043_0042_0041_0040) begin
      miscompares++;
      $display("FAIL d_fill_i_hold: i_rdata=%h want 0043004200410040", i_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] g_addr [4];
    int          g_cyc  [4];
    int          n = 0;
    apply_reset();
    i_req = 1'b1; i_addr = 14'h0005;
    d_req = 1'b1; d_we = 1'b0; d_addr = 14'h0006;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if ((mem_re || mem_we) && n < 4) begin
        g_addr[n] = mem_addr; g_cyc[n] = c; n++;
      end
      if (i_done) begin
        vectors++;
        if (i_rdata !== init_line(14'h0005)) begin
          miscompares++;
          $display("FAIL b2b_i_data: i_rdata=%h want %h", i_rdata, init_line(14'h0005));
        end
      end
      if (d_done) begin
        vectors++;
        if (d_rdata !== init_line(14'h0006)) begin
          miscompares++;
          $display("FAIL b2b_d_data: d_rdata=%h want %h", d_rdata, init_line(14'h0006));
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    repeat (8) @(negedge clk);
    vectors++;
    if (n != 4) begin
      miscompares++;
      $display("FAIL b2b_count: grants=%0d want 4", n);
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (g_addr[k] !== ((k % 2 == 0) ? 14'h0006 : 14'h0005) || g_cyc[k] != 1 + 7 * k) begin
          miscompares++;
          $display("FAIL b2b_grant%0d: addr=%h cycle=%0d want %h cycle %0d",
                   k, g_addr[k], g_cyc[k], (k % 2 == 0) ? 14'h0006 : 14'h0005, 1 + 7 * k);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    logic [63:0] rd;
    int          lat;
    logic        seen;
    i_req = 1'b1; i_addr = 14'h0030;
    repeat (3) @(negedge clk);  // T2, in WAIT
    rst = 1'b1;
    i_req = 1'b0;
    #1;
    vectors++;
    if ({busy, mem_re, mem_we, i_done, d_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_async: busy/re/we/i_done/d_done=%b want 00000",
               {busy, mem_re, mem_we, i_done, d_done});
    end
    @(negedge clk);
    vectors++;
    if ({busy, mem_re, mem_we, i_done, d_done} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_mid_edge: busy/re/we/i_done/d_done=%b want 00000",
               {busy, mem_re, mem_we, i_done, d_done});
    end
    rst = 1'b0;
    @(negedge clk);
    run_access(1'b0, 1'b0, 14'h0011, '0, rd, lat, seen);
    vectors++;
    if (!seen || lat != 6 || rd !== 64'h0047_0046_0045_0044) begin
      miscompares++;
      $display("FAIL reset_mid_recover: seen=%b latency=%0d rdata=%h want 1 6 0047004600450044",
               seen, lat, rd);
    end
  endtask

  task automatic test_timeout();
    logic [63:0] rd;
    int          lat;
    logic        seen;
    stall = 1'b1;
    i_req = 1'b1; i_addr = 14'h0012;
    repeat (16) @(negedge clk);  // T15: last allowed wait cycle
    vectors++;
    if (err !== 1'b0 || i_done !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_pre: err=%b i_done=%b busy=%b want 0 0 1", err, i_done, busy);
    end
    @(negedge clk);  // T16
    vectors++;
    if (i_done !== 1'b1 || i_rdata !== '0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_done: i_done=%b i_rdata=%h err=%b want 1 0 1", i_done, i_rdata, err);
    end
    i_req = 1'b0; stall = 1'b0;
    @(negedge clk);

    run_access(1'b1, 1'b0, 14'h0020, '0, rd, lat, seen);
    vectors++;
    if (!seen || rd !== 64'hDEADBEEF_CAFEF00D || err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: seen=%b rdata=%h err=%b want 1 deadbeefcafef00d 1", seen, rd, err);
    end
    apply_reset();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_clear: err=%b want 0", err);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_i_read();
    test_d_write_fill();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mem_arbiter
